// File: rtl/jtldtest_pkg.sv
// Shared types and helpers for the ldtest SDRAM download verifier.
// The optional per-bank CRC (JTLDTEST_CRC_EN) uses crc16_byte below.
package jtldtest_pkg;

    typedef enum logic [1:0] {
        V_IDLE = 2'd0,
        V_REQ  = 2'd1,
        V_CMP  = 2'd2
    } vstate_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [1:0] bank_of(input logic [24:0] addr, input int ba_aw);
        logic [24:0] sh;
        sh = addr >> ba_aw;
        return sh[1:0];
    endfunction

    // CRC-16/CCITT, MSB first, one byte per call
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/jtldtest_bankstat.sv
// Per-bank verify statistics: sticky bad flag, saturating error counter
// and, when JTLDTEST_CRC_EN is defined, a CRC over every compared read-back byte.
module jtldtest_bankstat
    import jtldtest_pkg::*;
#(
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            cmp,
    input  logic            miss,
`ifdef JTLDTEST_CRC_EN
    input  logic [7:0]      rb_byte,
    output logic [15:0]     crc,
`endif
    output logic            bad,
    output logic [ERRW-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad <= 1'b0;
            cnt <= '0;
        end else if (clr) begin
            bad <= 1'b0;
            cnt <= '0;
        end else if (cmp && miss) begin
            bad <= 1'b1;
            if (cnt != {ERRW{1'b1}}) cnt <= cnt + 1'b1;
        end
    end

`ifdef JTLDTEST_CRC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      crc <= CRC_INIT;
        else if (clr) crc <= CRC_INIT;
        else if (cmp) crc <= crc16_byte(crc, rb_byte);
    end
`endif

endmodule

// File: rtl/jtldtest_verify.sv
// SDRAM download verifier: alternates write and verify passes and compares each
// downloaded byte with its read-back. Optional per-bank CRC output: JTLDTEST_CRC_EN.
//
//   state  | meaning
//   V_IDLE | waiting for a verify-pass byte strobe
//   V_REQ  | read request outstanding, timeout counter running
//   V_CMP  | read-back byte registered, compare against downloaded byte
module jtldtest_verify
    import jtldtest_pkg::*;
#(
    parameter int BANKS = 4,
    parameter int BA_AW = 23,
    parameter int ERRW  = 8,
    parameter int SWAB  = 1,
    parameter int TOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  downloading,
    input  logic [24:0]           ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    input  logic                  ioctl_wr,
    output logic                  dwnld_busy,
    output logic                  phase,
    output logic                  rd_req,
    output logic [1:0]            rd_ba,
    output logic [BA_AW-2:0]      rd_addr,
    input  logic                  rd_ok,
    input  logic [15:0]           rd_data,
    output logic [BANKS-1:0]      bad,
    output logic [BANKS*ERRW-1:0] err_cnt,
    output logic                  first_bad_vld,
    output logic [24:0]           first_bad_addr,
    output logic                  overrun,
    output logic                  timeout,
`ifdef JTLDTEST_CRC_EN
    output logic [BANKS*16-1:0]   crc,
`endif
    output logic                  pass_done
);

    localparam int TW = (TOUT < 2) ? 1 : $clog2(TOUT + 1);

    vstate_t        st;
    logic           dl_q, wr_q, armed;
    logic [24:0]    la;
    logic [7:0]     ld, rb, sel;
    logic [TW-1:0]  tcnt;
    logic [1:0]     lba;
    logic           wr_rise, clr, miss;

    assign wr_rise    = ioctl_wr & ~wr_q;
    assign clr        = wr_rise & ~phase & armed;
    assign lba        = bank_of(la, BA_AW);
    assign miss       = (st == V_CMP) && (rb != ld);
    assign dwnld_busy = dl_q & ~phase;

    // byte lane: SWAB puts the even byte in the upper half of the word
    always_comb begin
        sel = rd_data[7:0];
        if (la[0] ^ (SWAB != 0)) sel = rd_data[15:8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_q           <= 1'b0;
            wr_q           <= 1'b0;
            phase          <= 1'b0;
            pass_done      <= 1'b0;
            armed          <= 1'b1;
            st             <= V_IDLE;
            la             <= '0;
            ld             <= '0;
            rb             <= '0;
            tcnt           <= '0;
            rd_req         <= 1'b0;
            rd_ba          <= '0;
            rd_addr        <= '0;
            first_bad_vld  <= 1'b0;
            first_bad_addr <= '0;
            overrun        <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            dl_q      <= downloading;
            wr_q      <= ioctl_wr;
            pass_done <= 1'b0;

            if (dl_q && !downloading) begin
                phase     <= ~phase;
                pass_done <= phase;
                if (phase) armed <= 1'b1;
            end

            if (clr) begin
                armed          <= 1'b0;
                first_bad_vld  <= 1'b0;
                first_bad_addr <= '0;
                overrun        <= 1'b0;
                timeout        <= 1'b0;
            end

            if (wr_rise && st != V_IDLE) overrun <= 1'b1;

            case (st)
                V_IDLE: begin
                    if (wr_rise && phase) begin
                        la <= ioctl_addr;
                        ld <= ioctl_dout;
                        if (32'(bank_of(ioctl_addr, BA_AW)) < BANKS) begin
                            st      <= V_REQ;
                            rd_req  <= 1'b1;
                            rd_ba   <= bank_of(ioctl_addr, BA_AW);
                            rd_addr <= ioctl_addr[BA_AW-1:1];
                            tcnt    <= TW'(TOUT);
                        end
                    end
                end
                V_REQ: begin
                    if (rd_ok) begin
                        rb     <= sel;
                        rd_req <= 1'b0;
                        st     <= V_CMP;
                    end else if (tcnt == '0) begin
                        timeout <= 1'b1;
                        rd_req  <= 1'b0;
                        st      <= V_IDLE;
                    end else begin
                        tcnt <= tcnt - 1'b1;
                    end
                end
                V_CMP: begin
                    st <= V_IDLE;
                    if (miss && !first_bad_vld) begin
                        first_bad_vld  <= 1'b1;
                        first_bad_addr <= la;
                    end
                end
                default: st <= V_IDLE;
            endcase
        end
    end

    for (genvar n = 0; n < BANKS; n++) begin : g_bank
        logic [ERRW-1:0] cnt_n;
        jtldtest_bankstat #(.ERRW(ERRW)) u_stat (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .cmp     (st == V_CMP && lba == 2'(n)),
            .miss    (miss),
`ifdef JTLDTEST_CRC_EN
            .rb_byte (rb),
            .crc     (crc[n*16 +: 16]),
`endif
            .bad     (bad[n]),
            .cnt     (cnt_n)
        );
        assign err_cnt[n*ERRW +: ERRW] = cnt_n;
    end

endmodule
